// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: datapath-side controls and display-pin outputs of the scan driver
interface seg7_scan_driver_if #(parameter int NUM_DIGITS = 4);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;
  modport master (output enable, load, digits, dp_in, blank_lz, input seg, dp_n, an, frame_done);
  modport slave  (input enable, load, digits, dp_in, blank_lz, output seg, dp_n, an, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit seven-segment driver with guard time,
// leading-zero blanking and frame-synchronous digit loading
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter int GUARD      = 8,
  parameter int HEX_MODE   = 1
) (
  input  logic clk,
  input  logic rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4*NUM_DIGITS;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         pend, shadow;
  logic [NUM_DIGITS-1:0] pend_dp, shadow_dp, hi_zero;
  logic                  pend_valid, last_slot, wrap, xfer, blank;
  logic [3:0]            code;
  logic [6:0]            glyph;
  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return HEX_MODE != 0 ? 7'b0001000 : 7'h7F;
      4'hB: return HEX_MODE != 0 ? 7'b1100000 : 7'h7F;
      4'hC: return HEX_MODE != 0 ? 7'b0110001 : 7'h7F;
      4'hD: return HEX_MODE != 0 ? 7'b1000010 : 7'h7F;
      4'hE: return HEX_MODE != 0 ? 7'b0110000 : 7'h7F;
      default: return HEX_MODE != 0 ? 7'b0111000 : 7'h7F;
    endcase
  endfunction
  // hi_zero[g]: digit g and every digit above it hold code 0
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
    assign hi_zero[g] = shadow[DW-1:4*g] == '0;
  end
  always_comb begin
    last_slot = cnt == CW'(DIV-1);
    wrap      = last_slot && idx == IW'(NUM_DIGITS-1);
    xfer      = pend_valid && (!bus.enable || wrap);
    code      = shadow[4*idx +: 4];
    blank     = bus.blank_lz && idx != '0 && hi_zero[idx];
    glyph     = blank ? 7'h7F : decode(code);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      idx            <= '0;
      pend           <= '0;
      pend_dp        <= '0;
      shadow         <= '0;
      shadow_dp      <= '0;
      pend_valid     <= 1'b0;
      bus.seg        <= 7'h7F;
      bus.dp_n       <= 1'b1;
      bus.an         <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      if (bus.load) begin
        pend    <= bus.digits;
        pend_dp <= bus.dp_in;
      end
      if (xfer) begin
        shadow    <= pend;
        shadow_dp <= pend_dp;
      end
      pend_valid <= bus.load || (pend_valid && !xfer);
      if (!bus.enable) begin
        cnt            <= '0;
        idx            <= '0;
        bus.seg        <= 7'h7F;
        bus.dp_n       <= 1'b1;
        bus.an         <= '1;
        bus.frame_done <= 1'b0;
      end else begin
        cnt            <= last_slot ? '0 : cnt + 1'b1;
        idx            <= wrap ? '0 : idx + IW'(last_slot);
        bus.seg        <= glyph;
        bus.dp_n       <= ~shadow_dp[idx];
        bus.an         <= 32'(cnt) >= GUARD ? ~(NUM_DIGITS'(1) << idx) : '1;
        bus.frame_done <= wrap;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench with a frame-position model checked every cycle
module tb_seg7_scan_driver;
  localparam int N = 4, D = 4, G = 1;
  localparam logic [6:0] GLYPH [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
    7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  localparam logic [6:0] LIT1234 [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
  localparam logic [3:0] ANL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic clk = 0, rst_n = 1;
  int total = 0, bad = 0;
  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();
  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus0 ();
  assign bus0.enable   = bus.enable;
  assign bus0.load     = bus.load;
  assign bus0.digits   = bus.digits;
  assign bus0.dp_in    = bus.dp_in;
  assign bus0.blank_lz = bus.blank_lz;
  seg7_scan_driver #(.NUM_DIGITS(N), .DIV(D), .GUARD(G), .HEX_MODE(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  seg7_scan_driver #(.NUM_DIGITS(N), .DIV(D), .GUARD(G), .HEX_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask
  function automatic logic [6:0] m_seg(input logic [15:0] d, input int i, input bit lz, input bit hex);
    logic [3:0] c;
    c = d[4*i +: 4];
    if (lz && i > 0 && (d >> (4*i)) == 16'd0) return 7'h7F;
    if (!hex && c > 9) return 7'h7F;
    return GLYPH[c];
  endfunction
  // model: slot position is a plain count of enabled cycles since reset/disable
  int ticks;
  logic [15:0] m_sh, m_pend;
  logic [3:0] m_shdp, m_pdp, e_an;
  bit m_pv;
  logic [6:0] e_seg, e_seg0;
  logic e_dp, e_fd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ticks <= 0; m_sh <= 0; m_pend <= 0; m_shdp <= 0; m_pdp <= 0; m_pv <= 0;
      e_seg <= 7'h7F; e_seg0 <= 7'h7F; e_dp <= 1; e_an <= 4'hF; e_fd <= 0;
    end else begin
      if (bus.load) begin
        m_pend <= bus.digits;
        m_pdp  <= bus.dp_in;
      end
      if (m_pv && (!bus.enable || ticks % (N*D) == N*D-1)) begin
        m_sh <= m_pend; m_shdp <= m_pdp; m_pv <= bus.load;
      end else if (bus.load) m_pv <= 1;
      if (!bus.enable) begin
        ticks <= 0; e_seg <= 7'h7F; e_seg0 <= 7'h7F; e_dp <= 1; e_an <= 4'hF; e_fd <= 0;
      end else begin
        ticks  <= ticks + 1;
        e_seg  <= m_seg(m_sh, (ticks / D) % N, bus.blank_lz, 1);
        e_seg0 <= m_seg(m_sh, (ticks / D) % N, bus.blank_lz, 0);
        e_dp   <= ~m_shdp[(ticks / D) % N];
        e_an   <= (ticks % D >= G) ? ~(4'b0001 << ((ticks / D) % N)) : 4'hF;
        e_fd   <= ticks % (N*D) == N*D-1;
      end
    end
  end
  always @(negedge clk) begin
    chk("seg", 32'(bus.seg), 32'(e_seg));
    chk("seg_hex0", 32'(bus0.seg), 32'(e_seg0));
    chk("dp_n", 32'(bus.dp_n), 32'(e_dp));
    chk("an", 32'(bus.an), 32'(e_an));
    chk("an_hex0", 32'(bus0.an), 32'(e_an));
    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
    chk("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_fd();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) return;
    end
    total++; bad++;
    $display("FAIL fd_timeout actual=none required=pulse");
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_seg"}, 32'(bus.seg), 32'h7F);
    chk({nm, "_seg0"}, 32'(bus0.seg), 32'h7F);
    chk({nm, "_an"}, 32'(bus.an), 32'hF);
    chk({nm, "_dp"}, 32'(bus.dp_n), 32'd1);
    chk({nm, "_fd"}, 32'(bus.frame_done), 32'd0);
  endtask
  initial begin
    bus.enable = 0; bus.load = 0; bus.digits = 0; bus.dp_in = 0; bus.blank_lz = 0;
    #1 rst_n = 0;
    #1 chk_reset("rst");
    step(2);
    rst_n = 1; bus.enable = 1; bus.digits = 16'h1234; bus.dp_in = 4'b0100; bus.load = 1;
    step(1); bus.load = 0;
    wait_fd();
    step(1); chk("g0_an", 32'(bus.an), 32'hF); chk("g0_seg", 32'(bus.seg), 32'(LIT1234[0]));
    step(1); chk("d0_an", 32'(bus.an), 32'(ANL[0]));
    for (int d = 1; d < 4; d++) begin
      step(4);
      chk("d_seg", 32'(bus.seg), 32'(LIT1234[d]));
      chk("d_an", 32'(bus.an), 32'(ANL[d]));
      chk("d_dp", 32'(bus.dp_n), d == 2 ? 32'd0 : 32'd1);
    end
    step(2); chk("fd16", 32'(bus.frame_done), 32'd1);
    bus.digits = 16'h00A0; bus.dp_in = 0; bus.blank_lz = 1; bus.load = 1;
    step(1); bus.load = 0;
    wait_fd();
    step(1); chk("lz_d0", 32'(bus.seg), 32'b0000001);
    step(5); chk("lz_d1", 32'(bus.seg), 32'b0001000); chk("lz_d1_hex0", 32'(bus0.seg), 32'h7F);
    step(4); chk("lz_d2", 32'(bus.seg), 32'h7F);
    step(4); chk("lz_d3", 32'(bus.seg), 32'h7F);
    bus.blank_lz = 0;
    step(16); chk("nolz_d3", 32'(bus.seg), 32'b0000001);
    step(8); bus.digits = 16'h5555; bus.load = 1;
    step(1); bus.load = 0;
    step(3); chk("old_d2", 32'(bus.seg), 32'b0000001);
    step(4); chk("old_d3", 32'(bus.seg), 32'b0000001);
    wait_fd();
    step(2); chk("new5_d0", 32'(bus.seg), 32'b0100100);
    step(1); bus.digits = 16'h1111; bus.load = 1;
    step(1); bus.load = 0;
    step(3); bus.digits = 16'h2222; bus.load = 1;
    step(1); bus.load = 0;
    wait_fd();
    step(2); chk("last_wins", 32'(bus.seg), 32'b0010010);
    bus.digits = 16'h0009; bus.load = 1;
    step(1); bus.load = 0; bus.enable = 0;
    step(1); chk("dis_an", 32'(bus.an), 32'hF); chk("dis_seg", 32'(bus.seg), 32'h7F);
    bus.enable = 1;
    step(1); chk("reen_guard_an", 32'(bus.an), 32'hF); chk("reen_seg", 32'(bus.seg), 32'b0000100);
    step(1); chk("reen_an", 32'(bus.an), 32'b1110);
    step(3);
    @(posedge clk); #2 rst_n = 0;
    #1 chk_reset("async");
    step(1); rst_n = 1;
    step(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
